fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage, directly upstream of decode. Owns the PC and runs a
//  REQ/RDY handshake to instruction memory. Drives the DE_NPC/DE_IR/DE_V latches
//  that decode consumes. Handles decode-branch stalls, branch resolution
//  redirects, trap redirects to DE_MTVEC, and MEM_STALL back-pressure.
// PARAMETERS
//  RESET_PC  64'h0          PC loaded on reset
//  NOP_IR    32'h00000013   IR driven with bubbles (addi x0,x0,0)
// PORTS
//  CLK            in   1   clock, all state on posedge
//  reset          in   1   asynchronous, active-low reset
//  IMEM_REQ       out  1   fetch request
//  IMEM_ADDR      out  64  fetch address, word aligned
//  IMEM_RDY       in   1   memory has IMEM_DATA for the current request
//  IMEM_DATA      in   32  instruction word
//  v_de_br_stall  in   1   decode holds a branch
//  MEM_STALL      in   1   pipeline hold; 1 freezes the DE latches
//  BR_RESOLVED    in   1   1-cycle pulse: branch outcome known
//  BR_NEXT_PC     in   64  correct post-branch PC (taken target or fallthrough)
//  WB_CS          in   1   trap/exception commit in WB
//  DE_MTVEC       in   64  trap vector from the CSR file
//  DE_NPC         out  64  PC+4 of the instruction in DE
//  DE_IR          out  32  instruction in DE
//  DE_V           out  1   DE instruction valid
// BEHAVIOUR
//  Reset (async, reset==0):
//   - FE_PC=RESET_PC, state=IDLE, br_pending=0, skid empty
//   - IMEM_REQ=0, DE_V=0, DE_IR=NOP_IR, DE_NPC=0
//  Handshake:
//   - A transfer happens on a posedge where IMEM_REQ&IMEM_RDY is 1.
//   - IMEM_ADDR stays stable while REQ=1 and RDY=0.
//   - REQ is never dropped before its transfer. RDY is ignored while REQ=0.
//  LD_DE = !MEM_STALL.
//   - DE load with a word: DE_IR=word, DE_NPC=addr+4 (mod 2^64), DE_V=1.
//   - DE load with a bubble: DE_IR=NOP_IR, DE_V=0, DE_NPC unchanged.
//  br_hit = v_de_br_stall & DE_V & LD_DE. When it is 1:
//   - DE loads a bubble and br_pending<=1.
//   - Any word transferred in that cycle or later is discarded until resolution.
//  FE_PC advances by 4 on every transfer that is not discarded.
//  States:
//   - IDLE: REQ=0; go to FETCH next cycle.
//   - FETCH: REQ=1, ADDR=FE_PC.
//       - transfer & LD_DE & !br_hit: load word into DE, stay in FETCH.
//       - transfer & !LD_DE: capture word/addr in the skid buffer, go to HOLD.
//       - transfer & br_hit: drop the word, go to BR_WAIT.
//       - no transfer & br_hit: go to DISCARD.
//   - HOLD: REQ=0.
//       - LD_DE & !br_hit: load skid into DE, go to FETCH.
//       - br_hit: drop skid, go to BR_WAIT.
//   - BR_WAIT: REQ=0, DE gets bubbles.
//       - BR_RESOLVED: FE_PC=BR_NEXT_PC, br_pending=0, go to FETCH.
//   - DISCARD: REQ=1 with the held ADDR.
//       - on transfer, drop the word; go to BR_WAIT if br_pending, else FETCH.
//  Redirects:
//   - Targets are forced to {target[63:2],2'b00}.
//   - Priority: WB_CS > BR_RESOLVED > sequential.
//   - WB_CS=1: FE_PC=DE_MTVEC, br_pending=0, skid cleared.
//     DE_V<=0 even when MEM_STALL=1 (the flush overrides the hold).
//     Next state is DISCARD if REQ=1 & !RDY, else FETCH.
//   - BR_RESOLVED outside BR_WAIT: FE_PC updated, br_pending cleared.
//     A transfer in flight completes through DISCARD.
//  While MEM_STALL=1 (no flush): DE_IR, DE_NPC and DE_V hold their values.
// STRUCTURE
//  - Shared rv_defs.vh holds OPC_BRANCH 7'b1100011, NOP_IR and the FSM state encodings.
//  - One sub-module, fe_skid_buf: 1-entry word/addr buffer with valid, load and clear.
//  - PC register, FSM and DE latches stay in fetch_stage.
// TESTING
//  1 Reset release, RESET_PC=0, RDY tied 1 -> IMEM_ADDR 0,4,8 on consecutive
//    cycles; DE_NPC 4,8,C; DE_V=1 from cycle 2.
//  2 RDY after 3 cycles -> ADDR held 3 cycles with REQ=1; DE_V=0 until the
//    word lands; DE_IR equals IMEM_DATA.
//  3 MEM_STALL=1 during a transfer -> word captured in skid; DE unchanged;
//    MEM_STALL=0 -> DE loads the skid word; REQ resumes the next cycle.
//  4 Branch in DE (v_de_br_stall=1, DE_V=1) -> DE_V=0, REQ=0; BR_RESOLVED
//    with BR_NEXT_PC=0x100 -> next ADDR=0x100, DE_NPC=0x104.
//  5 WB_CS=1, DE_MTVEC=0x800, with RDY low and MEM_STALL=1 -> DE_V=0 next
//    cycle; old request completes and is dropped; next ADDR=0x800.
//  6 WB_CS and BR_RESOLVED in the same cycle -> DE_MTVEC wins; reset asserted
//    mid-wait -> all outputs reach reset values immediately.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: bubble encoding,
// FSM state encoding and the redirect-target alignment helper.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_HOLD    = 3'd2,
        ST_BR_WAIT = 3'd3,
        ST_DISCARD = 3'd4
    } fe_state_e;

    function automatic logic [63:0] align_word(input logic [63:0] a);
        return {a[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fe_skid_buf.sv
// One-entry buffer that parks a fetched word and its address while the
// decode latches are held. Clear takes priority over load.
module fe_skid_buf (
    input  logic        CLK,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] word_in,
    input  logic [63:0] addr_in,
    output logic        valid,
    output logic [31:0] word,
    output logic [63:0] addr
);

    logic        valid_q, valid_d;
    logic [31:0] word_q, word_d;
    logic [63:0] addr_q, addr_d;

    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        addr_d  = addr_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            word_d  = word_in;
            addr_d  = addr_in;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            word_q  <= 32'h0;
            addr_q  <= 64'h0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
        end
    end

    assign valid = valid_q;
    assign word  = word_q;
    assign addr  = addr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the REQ/RDY handshake to
// instruction memory and drives the DE_NPC/DE_IR/DE_V decode latches.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_IR   = NOP_INSN
) (
    input  logic        CLK,
    input  logic        reset,
    output logic        IMEM_REQ,
    output logic [63:0] IMEM_ADDR,
    input  logic        IMEM_RDY,
    input  logic [31:0] IMEM_DATA,
    input  logic        v_de_br_stall,
    input  logic        MEM_STALL,
    input  logic        BR_RESOLVED,
    input  logic [63:0] BR_NEXT_PC,
    input  logic        WB_CS,
    input  logic [63:0] DE_MTVEC,
    output logic [63:0] DE_NPC,
    output logic [31:0] DE_IR,
    output logic        DE_V
);

    // Handshake: a word transfers on a posedge with IMEM_REQ & IMEM_RDY; once
    // raised, IMEM_REQ and IMEM_ADDR hold until that transfer occurs.
    fe_state_e   state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        br_pending_q, br_pending_d;
    logic [63:0] hold_addr_q, hold_addr_d;
    logic [63:0] de_npc_q, de_npc_d;
    logic [31:0] de_ir_q, de_ir_d;
    logic        de_v_q, de_v_d;

    logic        skid_load, skid_clear, skid_valid;
    logic [31:0] skid_word;
    logic [63:0] skid_addr;

    logic ld_de, xfer, br_hit, wait_rdy;

    assign IMEM_REQ  = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
    assign IMEM_ADDR = (state_q == ST_DISCARD) ? hold_addr_q : pc_q;
    assign ld_de     = !MEM_STALL;
    assign xfer      = IMEM_REQ & IMEM_RDY;
    assign br_hit    = v_de_br_stall & de_v_q & ld_de;
    assign wait_rdy  = IMEM_REQ & !IMEM_RDY;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        br_pending_d = br_pending_q | br_hit;
        hold_addr_d  = IMEM_ADDR;
        de_npc_d     = de_npc_q;
        de_ir_d      = de_ir_q;
        de_v_d       = de_v_q;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        // Any cycle the latches load without a word, decode sees a bubble.
        if (ld_de) begin
            de_ir_d = NOP_IR;
            de_v_d  = 1'b0;
        end
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (xfer && !ld_de) begin
                    skid_load = 1'b1;
                    pc_d      = pc_q + 64'd4;
                    state_d   = ST_HOLD;
                end else if (xfer && br_hit) begin
                    state_d = ST_BR_WAIT;
                end else if (xfer) begin
                    de_ir_d  = IMEM_DATA;
                    de_npc_d = pc_q + 64'd4;
                    de_v_d   = 1'b1;
                    pc_d     = pc_q + 64'd4;
                end else if (br_hit) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_HOLD: begin
                if (br_hit) begin
                    skid_clear = 1'b1;
                    state_d    = ST_BR_WAIT;
                end else if (ld_de && skid_valid) begin
                    skid_clear = 1'b1;
                    de_ir_d    = skid_word;
                    de_npc_d   = skid_addr + 64'd4;
                    de_v_d     = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_BR_WAIT: state_d = state_q;
            ST_DISCARD: begin
                if (xfer) state_d = br_pending_d ? ST_BR_WAIT : ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
        // Redirects drop any word landing this cycle; an unfinished request
        // is drained through DISCARD so the memory sees a legal handshake.
        if (WB_CS) begin
            pc_d         = align_word(DE_MTVEC);
            br_pending_d = 1'b0;
            skid_load    = 1'b0;
            skid_clear   = 1'b1;
            de_npc_d     = de_npc_q;
            de_ir_d      = NOP_IR;
            de_v_d       = 1'b0;
            state_d      = wait_rdy ? ST_DISCARD : ST_FETCH;
        end else if (BR_RESOLVED) begin
            pc_d         = align_word(BR_NEXT_PC);
            br_pending_d = 1'b0;
            skid_load    = 1'b0;
            skid_clear   = 1'b1;
            if (ld_de) begin
                de_npc_d = de_npc_q;
                de_ir_d  = NOP_IR;
                de_v_d   = 1'b0;
            end
            state_d = wait_rdy ? ST_DISCARD : ST_FETCH;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            br_pending_q <= 1'b0;
            hold_addr_q  <= RESET_PC;
            de_npc_q     <= 64'h0;
            de_ir_q      <= NOP_IR;
            de_v_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            br_pending_q <= br_pending_d;
            hold_addr_q  <= hold_addr_d;
            de_npc_q     <= de_npc_d;
            de_ir_q      <= de_ir_d;
            de_v_q       <= de_v_d;
        end
    end

    fe_skid_buf u_skid (
        .CLK     (CLK),
        .reset   (reset),
        .load    (skid_load),
        .clear   (skid_clear),
        .word_in (IMEM_DATA),
        .addr_in (IMEM_ADDR),
        .valid   (skid_valid),
        .word    (skid_word),
        .addr    (skid_addr)
    );

    assign DE_NPC = de_npc_q;
    assign DE_IR  = de_ir_q;
    assign DE_V   = de_v_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a program-order stream model that
// checks handshake and decode-latch rules on every negedge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        reset;
    logic        IMEM_REQ;
    logic [63:0] IMEM_ADDR;
    logic        IMEM_RDY;
    logic [31:0] IMEM_DATA;
    logic        v_de_br_stall;
    logic        MEM_STALL;
    logic        BR_RESOLVED;
    logic [63:0] BR_NEXT_PC;
    logic        WB_CS;
    logic [63:0] DE_MTVEC;
    logic [63:0] DE_NPC;
    logic [31:0] DE_IR;
    logic        DE_V;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fetch_stage #(.RESET_PC(64'h0), .NOP_IR(NOP)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .IMEM_REQ      (IMEM_REQ),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_RDY      (IMEM_RDY),
        .IMEM_DATA     (IMEM_DATA),
        .v_de_br_stall (v_de_br_stall),
        .MEM_STALL     (MEM_STALL),
        .BR_RESOLVED   (BR_RESOLVED),
        .BR_NEXT_PC    (BR_NEXT_PC),
        .WB_CS         (WB_CS),
        .DE_MTVEC      (DE_MTVEC),
        .DE_NPC        (DE_NPC),
        .DE_IR         (DE_IR),
        .DE_V          (DE_V)
    );

    // Memory image: every word address holds a unique, non-NOP word.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {8'hC3, a[25:2]};
    endfunction

    assign IMEM_DATA = mem_word(IMEM_ADDR);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Stream model: valid decode entries must follow program order from the
    // last redirect, hold under stall, and be bubbles while a branch waits.
    logic        p_valid = 1'b0;
    logic        p_req, p_rdy, p_stall, p_brstall, p_dev, p_wbcs, p_brres;
    logic [63:0] p_addr, p_npc, p_mtvec, p_next;
    logic [31:0] p_ir;
    logic [63:0] exp_npc;
    logic        m_brp;

    always @(negedge CLK) begin
        if (!reset) begin
            chk("m_rst_req", IMEM_REQ, 0);
            chk("m_rst_dev", DE_V, 0);
            chk("m_rst_ir", DE_IR, NOP);
            chk("m_rst_npc", DE_NPC, 0);
            exp_npc = 64'h4;
            m_brp   = 1'b0;
            p_valid = 1'b0;
        end else begin
            if (p_valid) begin
                if (p_req && !p_rdy) begin
                    chk("m_req_held", IMEM_REQ, 1);
                    chk("m_addr_stable", IMEM_ADDR, p_addr);
                end
                if (p_wbcs) begin
                    chk("m_flush_dev", DE_V, 0);
                    exp_npc = {p_mtvec[63:2], 2'b00} + 64'd4;
                    m_brp   = 1'b0;
                end else if (p_brres) begin
                    exp_npc = {p_next[63:2], 2'b00} + 64'd4;
                    m_brp   = 1'b0;
                end else if (p_stall) begin
                    chk("m_hold_v", DE_V, p_dev);
                    chk("m_hold_ir", DE_IR, p_ir);
                    chk("m_hold_npc", DE_NPC, p_npc);
                end else if ((p_brstall && p_dev) || m_brp) begin
                    chk("m_br_bubble", DE_V, 0);
                    m_brp = 1'b1;
                end else if (DE_V) begin
                    chk("m_npc_seq", DE_NPC, exp_npc);
                    exp_npc = exp_npc + 64'd4;
                end
            end
            if (DE_V) chk("m_ir_mem", DE_IR, mem_word(DE_NPC - 64'd4));
            else      chk("m_ir_nop", DE_IR, NOP);
            if (IMEM_REQ) chk("m_addr_align", IMEM_ADDR[1:0], 0);
            p_valid   = 1'b1;
            p_req     = IMEM_REQ;
            p_rdy     = IMEM_RDY;
            p_addr    = IMEM_ADDR;
            p_stall   = MEM_STALL;
            p_brstall = v_de_br_stall;
            p_dev     = DE_V;
            p_ir      = DE_IR;
            p_npc     = DE_NPC;
            p_wbcs    = WB_CS;
            p_mtvec   = DE_MTVEC;
            p_brres   = BR_RESOLVED;
            p_next    = BR_NEXT_PC;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; IMEM_RDY = 1'b1; v_de_br_stall = 1'b0; MEM_STALL = 1'b0;
        BR_RESOLVED = 1'b0; BR_NEXT_PC = 64'h0; WB_CS = 1'b0; DE_MTVEC = 64'h0;
        #2 reset = 1'b0;
        step(); step();
        chk("rst_req", IMEM_REQ, 0);
        chk("rst_dev", DE_V, 0);
        chk("rst_ir", DE_IR, NOP);
        chk("rst_npc", DE_NPC, 0);

        // 1: sequential fetch with RDY tied high
        reset = 1'b1;
        step();
        chk("t1_req", IMEM_REQ, 1);
        chk("t1_addr0", IMEM_ADDR, 64'h0);
        chk("t1_dev0", DE_V, 0);
        step();
        chk("t1_addr4", IMEM_ADDR, 64'h4);
        chk("t1_dev1", DE_V, 1);
        chk("t1_npc4", DE_NPC, 64'h4);
        chk("t1_ir0", DE_IR, 32'hC300_0000);
        step();
        chk("t1_addr8", IMEM_ADDR, 64'h8);
        chk("t1_npc8", DE_NPC, 64'h8);
        step();
        chk("t1_npcc", DE_NPC, 64'hC);

        // 2: RDY withheld for three cycles
        IMEM_RDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_req", IMEM_REQ, 1);
            chk("t2_addr", IMEM_ADDR, 64'hC);
            chk("t2_dev", DE_V, 0);
        end
        IMEM_RDY = 1'b1;
        step();
        chk("t2_dev_land", DE_V, 1);
        chk("t2_ir", DE_IR, 32'hC300_0003);
        chk("t2_npc", DE_NPC, 64'h10);

        // 3: stall during a transfer goes through the skid buffer
        MEM_STALL = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t3_req_off", IMEM_REQ, 0);
            chk("t3_hold_npc", DE_NPC, 64'h10);
            chk("t3_hold_ir", DE_IR, 32'hC300_0003);
        end
        MEM_STALL = 1'b0;
        step();
        chk("t3_skid_npc", DE_NPC, 64'h14);
        chk("t3_skid_ir", DE_IR, 32'hC300_0004);
        chk("t3_skid_v", DE_V, 1);
        chk("t3_req_back", IMEM_REQ, 1);
        chk("t3_addr", IMEM_ADDR, 64'h14);

        // 4: branch held in decode, then resolved to 0x100
        v_de_br_stall = 1'b1;
        step();
        chk("t4_dev", DE_V, 0);
        chk("t4_req", IMEM_REQ, 0);
        v_de_br_stall = 1'b0;
        step();
        chk("t4_wait_req", IMEM_REQ, 0);
        chk("t4_wait_dev", DE_V, 0);
        BR_RESOLVED = 1'b1; BR_NEXT_PC = 64'h100;
        step();
        BR_RESOLVED = 1'b0;
        chk("t4_addr", IMEM_ADDR, 64'h100);
        chk("t4_req_on", IMEM_REQ, 1);
        step();
        chk("t4_npc", DE_NPC, 64'h104);
        chk("t4_v", DE_V, 1);
        chk("t4_ir", DE_IR, 32'hC300_0040);

        // 5: trap with an outstanding request and decode held
        IMEM_RDY = 1'b0; MEM_STALL = 1'b1; WB_CS = 1'b1; DE_MTVEC = 64'h800;
        step();
        WB_CS = 1'b0;
        chk("t5_dev", DE_V, 0);
        chk("t5_req_held", IMEM_REQ, 1);
        chk("t5_addr_old", IMEM_ADDR, 64'h104);
        IMEM_RDY = 1'b1;
        step();
        chk("t5_addr_vec", IMEM_ADDR, 64'h800);
        chk("t5_drop_dev", DE_V, 0);
        MEM_STALL = 1'b0;
        step();
        chk("t5_npc", DE_NPC, 64'h804);
        chk("t5_ir", DE_IR, 32'hC300_0200);

        // 6: trap beats branch resolution; vector is word-aligned
        WB_CS = 1'b1; DE_MTVEC = 64'h903; BR_RESOLVED = 1'b1; BR_NEXT_PC = 64'h200;
        step();
        WB_CS = 1'b0; BR_RESOLVED = 1'b0;
        chk("t6_addr", IMEM_ADDR, 64'h900);
        chk("t6_dev", DE_V, 0);
        step();
        chk("t6_npc", DE_NPC, 64'h904);
        IMEM_RDY = 1'b0;
        step(); step();
        chk("t6_wait_addr", IMEM_ADDR, 64'h904);
        reset = 1'b0;
        #1;
        chk("t6_rst_req", IMEM_REQ, 0);
        chk("t6_rst_dev", DE_V, 0);
        chk("t6_rst_ir", DE_IR, NOP);
        chk("t6_rst_npc", DE_NPC, 0);
        step();
        reset = 1'b1; IMEM_RDY = 1'b1;
        step();
        chk("t6_restart_addr", IMEM_ADDR, 64'h0);
        chk("t6_restart_req", IMEM_REQ, 1);
        step();
        chk("t6_restart_npc", DE_NPC, 64'h4);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
